// File: rtl/alu_cmd_sequencer.sv
// Single-outstanding command sequencer for the 16-bit ALU datapath.
// Reads operands from an 8x16 register file, drives the ALU and writes back.
module alu_cmd_sequencer #(
   parameter int FAST_CYCLES   = 1,
   parameter int MULDIV_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [2:0]  cmd_dst,
   input  logic [2:0]  cmd_srca,
   input  logic [2:0]  cmd_srcb,
   input  logic [15:0] cmd_imm,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_sub,
   output logic [2:0]  alu_op_select,
   input  logic [15:0] alu_result,
   input  logic        alu_cout,
   input  logic        alu_overflow,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [4:0]  rsp_flags
);

   localparam int CW = 8;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t state, state_nx;

   logic [15:0]   rf [8];
   logic [2:0]    op_q;
   logic [2:0]    dst_q;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          rsp_hs;
   logic          done;
   logic          arith;
   logic          div_zero;

   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = cmd_valid & cmd_ready;
   assign rsp_hs    = rsp_valid & rsp_ready;
   // The counter holds the remaining settle edges; it hits 0 on this edge.
   assign done      = (state == EXEC) && (cnt == CW'(1));
   assign arith     = (op_q[2:1] == 2'b00) && !op_q[1];
   assign div_zero  = (op_q == 3'd5) && (alu_b == 16'h0000);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; ldi and illegal bypass the ALU.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept)
                  state_nx = (cmd_op[2:1] == 2'b11) ? RESP : EXEC;
         EXEC: if (done)   state_nx = RESP;
         RESP: if (rsp_hs) state_nx = IDLE;
         default:          state_nx = IDLE;
      endcase
   end

   // Operand launch, settle count, result capture and writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) rf[i] <= '0;
         op_q          <= '0;
         dst_q         <= '0;
         cnt           <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_sub       <= 1'b0;
         alu_op_select <= '0;
         rsp_data      <= '0;
         rsp_flags     <= '0;
      end else begin
         if (accept) begin
            op_q          <= cmd_op;
            dst_q         <= cmd_dst;
            alu_a         <= rf[cmd_srca];
            alu_b         <= rf[cmd_srcb];
            alu_op_select <= cmd_op;
            alu_sub       <= (cmd_op == 3'd1);
            cnt           <= cmd_op[2] ? CW'(MULDIV_CYCLES)
                                       : CW'(FAST_CYCLES);
            if (cmd_op == 3'd6) begin
               rf[cmd_dst] <= cmd_imm;
               rsp_data    <= cmd_imm;
               rsp_flags   <= {3'b000, cmd_imm[15],
                               cmd_imm == 16'h0000};
            end else if (cmd_op == 3'd7) begin
               rsp_data  <= '0;
               rsp_flags <= 5'b10000;
            end
         end
         if (state == EXEC) begin
            cnt <= cnt - CW'(1);
            if (done) begin
               if (div_zero) begin
                  rsp_data  <= 16'hFFFF;
                  rsp_flags <= 5'b10000;
               end else begin
                  rf[dst_q] <= alu_result;
                  rsp_data  <= alu_result;
                  rsp_flags <= {1'b0,
                                arith & alu_overflow,
                                arith & alu_cout,
                                alu_result[15],
                                alu_result == 16'h0000};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural 16-bit ALU.
// Directed commands push expected responses; a monitor pops on handshake.
module tb_alu_cmd_sequencer;

   localparam int FAST = 1;
   localparam int MD   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [2:0]  cmd_dst;
   logic [2:0]  cmd_srca;
   logic [2:0]  cmd_srcb;
   logic [15:0] cmd_imm;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_sub;
   logic [2:0]  alu_op_select;
   logic [15:0] alu_result;
   logic        alu_cout;
   logic        alu_overflow;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [4:0]  rsp_flags;

   typedef struct packed {
      logic [15:0] d;
      logic [4:0]  f;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   alu_cmd_sequencer #(
      .FAST_CYCLES(FAST),
      .MULDIV_CYCLES(MD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_dst(cmd_dst),
      .cmd_srca(cmd_srca),
      .cmd_srcb(cmd_srcb),
      .cmd_imm(cmd_imm),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_sub(alu_sub),
      .alu_op_select(alu_op_select),
      .alu_result(alu_result),
      .alu_cout(alu_cout),
      .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .rsp_flags(rsp_flags)
   );

   always #5 clk = ~clk;

   // Combinational ALU; divide by zero returns junk the DUT must ignore.
   always_comb begin
      logic [16:0] s;
      s            = '0;
      alu_result   = '0;
      alu_cout     = 1'b0;
      alu_overflow = 1'b0;
      case (alu_op_select)
         3'd0: begin
            s = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result   = s[15:0];
            alu_cout     = s[16];
            alu_overflow = (alu_a[15] == alu_b[15]) &&
                           (s[15] != alu_a[15]);
         end
         3'd1: begin
            s = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
            alu_result   = s[15:0];
            alu_cout     = s[16];
            alu_overflow = (alu_a[15] != alu_b[15]) &&
                           (s[15] != alu_a[15]);
         end
         3'd2: alu_result = alu_a & alu_b;
         3'd3: alu_result = alu_a | alu_b;
         3'd4: alu_result = alu_a * alu_b;
         3'd5: alu_result = (alu_b == 16'h0000) ? 16'h1234
                                                : alu_a / alu_b;
         default: alu_result = '0;
      endcase
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare each accepted response against the scoreboard.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got %0h expected none",
                     rsp_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_data", rsp_data, e.d);
            chk("rsp_flags", rsp_flags, e.f);
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (!cmd_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("return_idle", cmd_ready, 1);
   endtask

   task automatic issue(input logic [2:0]  op,
                        input logic [2:0]  dst,
                        input logic [2:0]  sa,
                        input logic [2:0]  sb,
                        input logic [15:0] imm,
                        input logic [15:0] ed,
                        input logic [4:0]  ef);
      int n;
      int lat;
      lat = (op >= 3'd6) ? 0 : (op >= 3'd4) ? MD : FAST;
      q.push_back(exp_t'{ed, ef});
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_dst   = dst;
      cmd_srca  = sa;
      cmd_srcb  = sb;
      cmd_imm   = imm;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, lat);
      wait_idle();
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_dst   = '0;
      cmd_srca  = '0;
      cmd_srcb  = '0;
      cmd_imm   = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_flags", rsp_flags, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_op_select, 0);
      chk("rst_alu_sub", alu_sub, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      issue(3'd6, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 5'b00000);
      issue(3'd6, 3'd2, 3'd0, 3'd0, 16'h0003, 16'h0003, 5'b00000);
      issue(3'd0, 3'd3, 3'd1, 3'd2, 16'h0,    16'h0008, 5'b00000);
      issue(3'd1, 3'd4, 3'd2, 3'd1, 16'h0,    16'hFFFE, 5'b00010);
      issue(3'd6, 3'd5, 3'd0, 3'd0, 16'h7FFF, 16'h7FFF, 5'b00000);
      issue(3'd6, 3'd6, 3'd0, 3'd0, 16'h0001, 16'h0001, 5'b00000);
      issue(3'd0, 3'd7, 3'd5, 3'd6, 16'h0,    16'h8000, 5'b01010);
      issue(3'd5, 3'd4, 3'd1, 3'd0, 16'h0,    16'hFFFF, 5'b10000);
      issue(3'd3, 3'd4, 3'd4, 3'd4, 16'h0,    16'hFFFE, 5'b00010);
      issue(3'd4, 3'd0, 3'd1, 3'd2, 16'h0,    16'h000F, 5'b00000);
      issue(3'd5, 3'd5, 3'd0, 3'd1, 16'h0,    16'h0003, 5'b00000);
      issue(3'd2, 3'd6, 3'd3, 3'd0, 16'h0,    16'h0008, 5'b00000);
      issue(3'd7, 3'd1, 3'd0, 3'd0, 16'h0,    16'h0000, 5'b10000);
      issue(3'd3, 3'd1, 3'd1, 3'd1, 16'h0,    16'h0005, 5'b00000);
      issue(3'd1, 3'd2, 3'd2, 3'd2, 16'h0,    16'h0000, 5'b00101);

      // Response backpressure.
      rsp_ready = 1'b0;
      q.push_back(exp_t'{16'h1234, 5'b00000});
      cmd_valid = 1'b1;
      cmd_op    = 3'd6;
      cmd_dst   = 3'd6;
      cmd_imm   = 16'h1234;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_data", rsp_data, 16'h1234);
         chk("bp_cmd_ready", cmd_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_idle();

      // Reset while a mul is settling: no response, registers cleared.
      cmd_valid = 1'b1;
      cmd_op    = 3'd4;
      cmd_dst   = 3'd3;
      cmd_srca  = 3'd1;
      cmd_srcb  = 3'd1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      chk("exec_busy", cmd_ready, 0);
      chk("exec_sel", alu_op_select, 3'd4);
      rst = 1'b1;
      #2;
      chk("rst_exec_alu_a", alu_a, 0);
      chk("rst_exec_ready", cmd_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("rst_no_rsp", rsp_valid, 0);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++)
         issue(3'd3, 3'(i), 3'(i), 3'(i), 16'h0, 16'h0000, 5'b00001);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
